// File: rtl/mrsc_pkg.sv
// Shared widths, codeword field offsets and the 4x4 data-matrix type for the MRSC encoder.
// Optional parity field is controlled by the MRSC_PARITY_EN macro.
package mrsc_pkg;

  localparam int DATA_W   = 16;
  localparam int CODE_W   = 32;
  localparam int DATA_LSB = 16;
  localparam int CHK_LSB  = 8;
  localparam int PAR_LSB  = 0;
  localparam int CHK_W    = 8;
  localparam int PAR_W    = 8;

  // Ascending packed ranges make m[0][0] the word MSB, so m[r][c] == word[15-4r-c].
  typedef logic [0:3][0:3] mrsc_matrix_t;

  function automatic mrsc_matrix_t to_matrix(input logic [DATA_W-1:0] word);
    return mrsc_matrix_t'(word);
  endfunction

endpackage

// File: rtl/mrsc_check_gen.sv
// Combinational MRSC check-bit and row-parity generation for one 16-bit data word.
// Row parity exists only when MRSC_PARITY_EN is defined; otherwise it is tied to zero.
module mrsc_check_gen #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data_word,
  output logic [7:0]        chk_bits,
  output logic [7:0]        par_bits
);
  import mrsc_pkg::*;

  mrsc_matrix_t m;

  assign m = to_matrix(data_word);

  // Position p (A,B,C,D) sits at (p/2, p%2) inside a quadrant; Q1/Q3 share columns 0-1, Q2/Q4 columns 2-3.
  always_comb begin
    chk_bits = '0;
    for (int p = 0; p < 4; p++) begin
      chk_bits[7-2*p] = m[p/2][p%2]   ^ m[2+p/2][p%2];
      chk_bits[6-2*p] = m[p/2][2+p%2] ^ m[2+p/2][2+p%2];
    end
  end

`ifdef MRSC_PARITY_EN
  always_comb begin
    par_bits = '0;
    for (int r = 0; r < 4; r++) begin
      par_bits[7-2*r] = m[r][0] ^ m[r][1];
      par_bits[6-2*r] = m[r][2] ^ m[r][3];
    end
  end
`else
  assign par_bits = '0;
`endif

endmodule

// File: rtl/mrsc_encoder.sv
// MRSC encoder top: one-cycle registered codeword {data, check bits, row parity}.
// Define MRSC_PARITY_EN to populate the parity field [7:0]; otherwise it reads as zero.
module mrsc_encoder #(
  parameter int DATA_W = 16,
  parameter int CODE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_word,
  output logic              out_valid,
  output logic [CODE_W-1:0] encoded_word
);
  import mrsc_pkg::*;

  logic [7:0]        chk_bits;
  logic [7:0]        par_bits;
  logic [CODE_W-1:0] next_word;

  mrsc_check_gen #(
    .DATA_W (DATA_W)
  ) u_check_gen (
    .data_word (in_word),
    .chk_bits  (chk_bits),
    .par_bits  (par_bits)
  );

  assign next_word[CODE_W-1:DATA_LSB]      = in_word;
  assign next_word[CHK_LSB+CHK_W-1:CHK_LSB] = chk_bits;
  assign next_word[PAR_LSB+PAR_W-1:PAR_LSB] = par_bits;

  // The codeword register only loads on a valid word so idle cycles hold the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      encoded_word <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        encoded_word <= next_word;
      end
    end
  end

endmodule

// File: tb/tb_mrsc_encoder.sv
// Scoreboard bench for mrsc_encoder: directed vectors, randomized traffic and async reset cases.
// Compile with the same MRSC_PARITY_EN setting as the RTL.
module tb_mrsc_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_word = 16'h0;
  logic        out_valid;
  logic [31:0] encoded_word;

  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held_word = 32'h0;

`ifdef MRSC_PARITY_EN
  localparam logic [31:0] EXP_80FA = 32'h80FA7C83;
  localparam logic [31:0] EXP_0400 = 32'h04000220;
`else
  localparam logic [31:0] EXP_80FA = 32'h80FA7C00;
  localparam logic [31:0] EXP_0400 = 32'h04000200;
`endif

  always #5 clk = ~clk;

  mrsc_encoder #(
    .DATA_W (16),
    .CODE_W (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .encoded_word (encoded_word)
  );

  // Reference model: build the matrix, pair quadrant Q1/Q3 and Q2/Q4 by position, then row parity.
  function automatic logic [31:0] ref_code(input logic [15:0] w);
    bit          m[4][4];
    int          q_row[4] = '{0, 0, 2, 2};
    int          q_col[4] = '{0, 2, 0, 2};
    logic [31:0] code;
    bit          qa, qb;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = w[15 - 4*r - c];
    code = {w, 16'h0000};
    for (int p = 0; p < 4; p++) begin
      qa = m[q_row[0] + p/2][q_col[0] + p%2];
      qb = m[q_row[2] + p/2][q_col[2] + p%2];
      code[15 - 2*p] = qa ^ qb;
      qa = m[q_row[1] + p/2][q_col[1] + p%2];
      qb = m[q_row[3] + p/2][q_col[3] + p%2];
      code[14 - 2*p] = qa ^ qb;
    end
`ifdef MRSC_PARITY_EN
    for (int r = 0; r < 4; r++) begin
      code[7 - 2*r] = m[r][0] ^ m[r][1];
      code[6 - 2*r] = m[r][2] ^ m[r][3];
    end
`endif
    return code;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] word);
    @(negedge clk);
    in_valid = valid;
    in_word  = word;
    if (valid) exp_q.push_back(ref_code(word));
  endtask

  task automatic applyKnown(input logic [15:0] word, input logic [31:0] expected);
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = word;
    exp_q.push_back(expected);
  endtask

  // Monitor: one look per cycle, just after the rising edge.
  initial begin
    logic [31:0] exp_word;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        held_word = 32'h0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("encoded_word", encoded_word, exp_word);
          held_word = exp_word;
        end
      end else begin
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          checkOutput("missing_out_valid", {31'b0, out_valid}, 32'd1);
        end else begin
          checkOutput("held_word", encoded_word, held_word);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_encoded_word", encoded_word, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyKnown(16'h80FA, EXP_80FA);
    applyKnown(16'h0000, 32'h00000000);
    applyKnown(16'h00FF, 32'h00FFFF00);
    applyKnown(16'h0400, EXP_0400);
    applyStimulus(1'b0, 16'h0);
    applyStimulus(1'b0, 16'h0);
    applyKnown(16'h80FA, EXP_80FA);
    applyKnown(16'h0400, EXP_0400);
    applyStimulus(1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0);

    applyStimulus(1'b1, 16'hFFFF);
    applyStimulus(1'b1, 16'h8000);
    applyStimulus(1'b1, 16'h0001);
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 9) < 7, 16'($urandom));
    applyStimulus(1'b0, 16'h0);

    applyStimulus(1'b1, 16'($urandom));
    applyStimulus(1'b1, 16'($urandom));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async_reset_encoded_word", encoded_word, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_word  = 16'h0400;
    exp_q.push_back(EXP_0400);
    applyStimulus(1'b0, 16'h0);
    applyStimulus(1'b0, 16'h0);

    for (int i = 0; i < 60; i++)
      applyStimulus($urandom_range(0, 1) == 1, 16'($urandom));
    applyStimulus(1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
